vec_lane_sched: RTL and testbench

Controller that sequences a bank of vector ALU lanes for one vector instruction at a time.
- Accepts a decoded instruction (opcode, SEW, operand type, operands) over a valid/ready issue port.
- Broadcasts the instruction to the lanes, asserts per-lane run, and collects each lane's per-step result slice into a VLEN-bit result buffer.
- Presents the assembled vector for register-file writeback over a valid/ready port.
- Sits between the vector decode stage and the vector register file.

---
 rtl/vec_pkg.sv | 33 +++
 rtl/vec_lane_sched_if.sv | 31 +++
 rtl/vec_result_buf.sv | 50 +++++
 rtl/vec_lane_sched.sv | 180 ++++++++++++++++++
 tb/tb_vec_lane_sched.sv | 369 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vec_pkg.sv
// Shared definitions for the vector lane scheduler: opcode and operand-type
// encodings, SEW codes, scheduler states and small decode helpers.
package vec_pkg;

   localparam logic [5:0] VADD = 6'b000000;
   localparam logic [5:0] VAND = 6'b001001;
   localparam logic [5:0] VOR  = 6'b001010;
   localparam logic [5:0] VXOR = 6'b001011;

   localparam logic [2:0] VV = 3'b001;
   localparam logic [2:0] VX = 3'b010;
   localparam logic [2:0] VI = 3'b100;

   localparam logic [2:0] SEW_8  = 3'd0;
   localparam logic [2:0] SEW_16 = 3'd1;
   localparam logic [2:0] SEW_32 = 3'd2;
   localparam logic [2:0] SEW_64 = 3'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_WB   = 2'd2
   } sched_state_t;

   function automatic logic opcode_ok(input logic [5:0] op);
      return (op == VADD) || (op == VAND) || (op == VOR) || (op == VXOR);
   endfunction

   function automatic logic op_type_ok(input logic [2:0] ot);
      return (ot == VV) || (ot == VX) || (ot == VI);
   endfunction

endpackage

// File: rtl/vec_lane_sched_if.sv
// Issue and writeback handshakes of the lane scheduler. The scheduler side
// uses the slave modport; decode stage / register file use master.
interface vec_lane_sched_if #(
   parameter int VLEN = 128
);
   logic            issue_valid;
   logic            issue_ready;
   logic [5:0]      issue_opcode;
   logic [2:0]      issue_vsew;
   logic [2:0]      issue_op_type;
   logic [1:0]      issue_nb_lanes;
   logic [4:0]      issue_vd_addr;
   logic [VLEN-1:0] issue_vs1;
   logic [VLEN-1:0] issue_vs2;
   logic            wb_valid;
   logic            wb_ready;
   logic [4:0]      wb_addr;
   logic [VLEN-1:0] wb_data;

   modport master (
      output issue_valid, issue_opcode, issue_vsew, issue_op_type,
             issue_nb_lanes, issue_vd_addr, issue_vs1, issue_vs2, wb_ready,
      input  issue_ready, wb_valid, wb_addr, wb_data
   );

   modport slave (
      input  issue_valid, issue_opcode, issue_vsew, issue_op_type,
             issue_nb_lanes, issue_vd_addr, issue_vs1, issue_vs2, wb_ready,
      output issue_ready, wb_valid, wb_addr, wb_data
   );
endinterface

// File: rtl/vec_result_buf.sv
// VLEN-bit result register with one windowed write port per lane; windows
// that would run past VLEN are ignored rather than wrapped.
module vec_result_buf #(
   parameter int VLEN   = 128,
   parameter int NLANES = 4,
   parameter int SLICE  = 8,
   parameter int IDXW   = 10
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    clr,
   input  logic [NLANES-1:0]       wr_en,
   input  logic [NLANES*IDXW-1:0]  wr_idx,
   input  logic [NLANES*SLICE-1:0] wr_data,
   output logic [VLEN-1:0]         data
);
   localparam int AW = $clog2(VLEN);

   logic [VLEN-1:0]   buf_reg, buf_next;
   logic [NLANES-1:0] win_ok;
   logic [AW-1:0]     win_base [NLANES];

   generate
      for (genvar gi = 0; gi < NLANES; gi++) begin : g_port
         assign win_ok[gi]   = wr_en[gi] &&
                               ((32'(wr_idx[gi*IDXW +: IDXW]) + 32'(SLICE)) <= 32'(VLEN));
         assign win_base[gi] = wr_idx[gi*IDXW +: AW];
      end
   endgenerate

   // Lanes own disjoint windows, so applying ports in order never loses a write.
   always_comb begin
      buf_next = buf_reg;
      for (int i = 0; i < NLANES; i++) begin
         if (win_ok[i]) begin
            buf_next[win_base[i] +: SLICE] = wr_data[i*SLICE +: SLICE];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn || clr) begin
         buf_reg <= '0;
      end else begin
         buf_reg <= buf_next;
      end
   end

   assign data = buf_reg;
endmodule

// File: rtl/vec_lane_sched.sv
// Sequences the vector lanes for one instruction at a time: accept, run the
// lanes while gathering their slices, then offer the vector for writeback.
module vec_lane_sched
   import vec_pkg::*;
#(
   parameter int VLEN       = 128,
   parameter int LANE_WIDTH = 3,
   parameter int NLANES     = 4,
   parameter int TIMEOUT    = 256
) (
   input  logic                 clk,
   input  logic                 resetn,
   vec_lane_sched_if.slave      bus,
   output logic [NLANES-1:0]    lane_run,
   output logic [5:0]           lane_opcode,
   output logic [2:0]           lane_vsew,
   output logic [2:0]           lane_op_type,
   output logic [1:0]           lane_nb_lanes,
   output logic [VLEN-1:0]      lane_vs1,
   output logic [VLEN-1:0]      lane_vs2,
   input  logic [64*NLANES-1:0] lane_vd,
   input  logic [10*NLANES-1:0] lane_idx,
   input  logic [NLANES-1:0]    lane_done,
   output logic                 busy,
   output logic                 err_illegal,
   output logic                 err_timeout
);
   localparam int SLICE = 1 << LANE_WIDTH;
   localparam int CNTW  = $clog2(TIMEOUT + 1);

   sched_state_t            state_reg, state_next;
   logic [NLANES-1:0]       lane_run_reg, lane_run_next, run_q_reg, done_q_reg;
   logic [5:0]              opcode_reg;
   logic [2:0]              vsew_reg, op_type_reg;
   logic [1:0]              nb_lanes_reg;
   logic [4:0]              vd_addr_reg;
   logic [VLEN-1:0]         vs1_reg, vs2_reg, buf_data;
   logic [CNTW-1:0]         cnt_reg, cnt_next;
   logic                    err_illegal_reg, err_illegal_next;
   logic                    err_timeout_reg, err_timeout_next;
   logic                    issue_fire, issue_legal, capture, buf_clr, all_done;
   logic [NLANES-1:0]       accept_mask, run_mask, wr_en, vd_hi_unused;
   logic [NLANES*SLICE-1:0] wr_data;

   assign issue_fire = bus.issue_valid & bus.issue_ready;

   generate
      for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
         assign accept_mask[gi]  = 32'(gi) < (32'd1 << bus.issue_nb_lanes);
         assign run_mask[gi]     = 32'(gi) < (32'd1 << nb_lanes_reg);
         assign wr_en[gi]        = (state_reg == ST_RUN) & run_q_reg[gi] & ~done_q_reg[gi];
         assign wr_data[gi*SLICE +: SLICE] = lane_vd[64*gi +: SLICE];
         assign vd_hi_unused[gi] = ^lane_vd[64*gi+SLICE +: 64-SLICE];
      end
   endgenerate

   assign all_done = &(lane_done | ~run_mask);

   // Active lanes must fit both the physical bank and the element count.
   always_comb begin
      issue_legal = 1'b1;
      if (!opcode_ok(bus.issue_opcode))  issue_legal = 1'b0;
      if (!op_type_ok(bus.issue_op_type)) issue_legal = 1'b0;
      if (bus.issue_vsew > SEW_64)        issue_legal = 1'b0;
      if ((32'd1 << bus.issue_nb_lanes) > 32'(NLANES)) issue_legal = 1'b0;
      if ((32'd1 << bus.issue_nb_lanes) >
          (32'(VLEN) >> ({1'b0, bus.issue_vsew} + 4'd3))) issue_legal = 1'b0;
   end

   always_comb begin
      state_next       = state_reg;
      lane_run_next    = lane_run_reg;
      cnt_next         = cnt_reg;
      capture          = 1'b0;
      buf_clr          = 1'b0;
      err_illegal_next = 1'b0;
      err_timeout_next = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (issue_fire) begin
               if (issue_legal) begin
                  capture       = 1'b1;
                  buf_clr       = 1'b1;
                  lane_run_next = accept_mask;
                  cnt_next      = '0;
                  state_next    = ST_RUN;
               end else begin
                  err_illegal_next = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (all_done) begin
               lane_run_next = '0;
               state_next    = ST_WB;
            end else if (cnt_reg == CNTW'(TIMEOUT - 1)) begin
               lane_run_next    = '0;
               err_timeout_next = 1'b1;
               state_next       = ST_IDLE;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         ST_WB: begin
            if (bus.wb_ready) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_reg       <= ST_IDLE;
         lane_run_reg    <= '0;
         run_q_reg       <= '0;
         done_q_reg      <= '0;
         cnt_reg         <= '0;
         err_illegal_reg <= 1'b0;
         err_timeout_reg <= 1'b0;
      end else begin
         state_reg       <= state_next;
         lane_run_reg    <= lane_run_next;
         run_q_reg       <= lane_run_reg;
         done_q_reg      <= lane_done;
         cnt_reg         <= cnt_next;
         err_illegal_reg <= err_illegal_next;
         err_timeout_reg <= err_timeout_next;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         opcode_reg   <= '0;
         vsew_reg     <= '0;
         op_type_reg  <= '0;
         nb_lanes_reg <= '0;
         vd_addr_reg  <= '0;
         vs1_reg      <= '0;
         vs2_reg      <= '0;
      end else if (capture) begin
         opcode_reg   <= bus.issue_opcode;
         vsew_reg     <= bus.issue_vsew;
         op_type_reg  <= bus.issue_op_type;
         nb_lanes_reg <= bus.issue_nb_lanes;
         vd_addr_reg  <= bus.issue_vd_addr;
         vs1_reg      <= bus.issue_vs1;
         vs2_reg      <= bus.issue_vs2;
      end
   end

   vec_result_buf #(
      .VLEN  (VLEN),
      .NLANES(NLANES),
      .SLICE (SLICE),
      .IDXW  (10)
   ) u_result_buf (
      .clk    (clk),
      .resetn (resetn),
      .clr    (buf_clr),
      .wr_en  (wr_en),
      .wr_idx (lane_idx),
      .wr_data(wr_data),
      .data   (buf_data)
   );

   assign bus.issue_ready = (state_reg == ST_IDLE);
   assign bus.wb_valid    = (state_reg == ST_WB);
   assign bus.wb_addr     = vd_addr_reg;
   assign bus.wb_data     = buf_data;
   assign busy            = (state_reg != ST_IDLE);
   assign err_illegal     = err_illegal_reg;
   assign err_timeout     = err_timeout_reg;
   assign lane_run        = lane_run_reg;
   assign lane_opcode     = opcode_reg;
   assign lane_vsew       = vsew_reg;
   assign lane_op_type    = op_type_reg;
   assign lane_nb_lanes   = nb_lanes_reg;
   assign lane_vs1        = vs1_reg;
   assign lane_vs2        = vs2_reg;
endmodule

// File: tb/tb_vec_lane_sched.sv
// Randomised bench for vec_lane_sched: byte-serial behavioural lanes drive the
// DUT, a queue-based scoreboard checks writeback against element-wise arithmetic.
module tb_vec_lane_sched;
   import vec_pkg::*;

   localparam int VLEN = 128;
   localparam int LW   = 3;
   localparam int NL   = 4;
   localparam int TMO  = 256;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   vec_lane_sched_if #(.VLEN(VLEN)) bus ();

   logic [NL-1:0]      lane_run;
   logic [5:0]         lane_opcode;
   logic [2:0]         lane_vsew, lane_op_type;
   logic [1:0]         lane_nb_lanes;
   logic [VLEN-1:0]    lane_vs1, lane_vs2;
   logic [64*NL-1:0]   lane_vd   = '0;
   logic [10*NL-1:0]   lane_idx  = '0;
   logic [NL-1:0]      lane_done = '0;
   logic               busy, err_illegal, err_timeout;

   vec_lane_sched #(.VLEN(VLEN), .LANE_WIDTH(LW), .NLANES(NL), .TIMEOUT(TMO)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .bus          (bus),
      .lane_run     (lane_run),
      .lane_opcode  (lane_opcode),
      .lane_vsew    (lane_vsew),
      .lane_op_type (lane_op_type),
      .lane_nb_lanes(lane_nb_lanes),
      .lane_vs1     (lane_vs1),
      .lane_vs2     (lane_vs2),
      .lane_vd      (lane_vd),
      .lane_idx     (lane_idx),
      .lane_done    (lane_done),
      .busy         (busy),
      .err_illegal  (err_illegal),
      .err_timeout  (err_timeout)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   bit tie_done = 1'b0;
   int stall_req = -1;

   typedef struct {
      logic [4:0]      addr;
      logic [VLEN-1:0] data;
      int              acc;
      int              lat;
   } exp_t;
   exp_t sb[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // ---------------- reference model (element-level) ----------------
   function automatic int ref_steps(input int sew, input int nb);
      int mult;
      mult = (sew + 3 >= LW) ? (1 << (sew + 3 - LW)) : 1;
      return ((VLEN >> (sew + 3)) / (1 << nb)) * mult;
   endfunction

   function automatic bit ref_legal(input logic [5:0] op, input logic [2:0] sew,
                                    input logic [2:0] ot, input logic [1:0] nb);
      bit ok;
      ok = (op == VADD || op == VAND || op == VOR || op == VXOR);
      ok = ok && (ot == VV || ot == VX || ot == VI);
      ok = ok && (sew <= 3);
      ok = ok && ((1 << nb) <= NL);
      if (sew <= 3) ok = ok && ((1 << nb) <= (VLEN >> (sew + 3)));
      return ok;
   endfunction

   function automatic logic [VLEN-1:0] ref_result(input logic [5:0] op, input logic [2:0] sew,
         input logic [2:0] ot, input logic [VLEN-1:0] v1, input logic [VLEN-1:0] v2);
      int esz, ne;
      logic [63:0] a, b, y;
      logic [VLEN-1:0] r;
      esz = 8 << sew;
      ne  = VLEN / esz;
      r   = '0;
      for (int e = 0; e < ne; e++) begin
         a = '0;
         b = '0;
         for (int k = 0; k < esz; k++) begin
            b[k] = v2[e*esz + k];
            a[k] = (ot == VV) ? v1[e*esz + k] : v1[k];
         end
         case (op)
            VADD:    y = a + b;
            VAND:    y = a & b;
            VOR:     y = a | b;
            default: y = a ^ b;
         endcase
         for (int k = 0; k < esz; k++) r[e*esz + k] = y[k];
      end
      return r;
   endfunction

   // ---------------- behavioural lanes (byte-serial, interleaved elements) ----------------
   int   lstep [NL];
   logic lcarry[NL];

   function automatic int lane_bit_idx(input int i, input int step);
      int esz, bps, nl;
      esz = 8 << int'(lane_vsew);
      bps = esz / 8;
      nl  = 1 << int'(lane_nb_lanes);
      return ((step / bps) * nl + i) * esz + (step % bps) * 8;
   endfunction

   function automatic logic [8:0] lane_byte(input int i, input int step, input logic cin);
      int bps, b, pos;
      logic [7:0] x, y;
      logic c;
      bps = (8 << int'(lane_vsew)) / 8;
      b   = step % bps;
      pos = lane_bit_idx(i, step);
      c   = (b == 0) ? 1'b0 : cin;
      x   = lane_vs2[pos +: 8];
      y   = (lane_op_type == VV) ? lane_vs1[pos +: 8] : lane_vs1[b*8 +: 8];
      case (lane_opcode)
         VADD:    return {1'b0, x} + {1'b0, y} + {8'd0, c};
         VAND:    return {1'b0, x & y};
         VOR:     return {1'b0, x | y};
         default: return {1'b0, x ^ y};
      endcase
   endfunction

   initial for (int i = 0; i < NL; i++) begin lstep[i] = 0; lcarry[i] = 1'b0; end

   always @(posedge clk) begin
      for (int i = 0; i < NL; i++) begin
         if (!lane_run[i]) begin
            lstep[i]              <= 0;
            lcarry[i]             <= 1'b0;
            lane_vd[64*i +: 64]   <= '0;
            lane_idx[10*i +: 10]  <= '0;
            lane_done[i]          <= 1'b0;
         end else if (lstep[i] < ref_steps(int'(lane_vsew), int'(lane_nb_lanes))) begin
            lane_vd[64*i +: 8]    <= 8'(lane_byte(i, lstep[i], lcarry[i]));
            lane_vd[64*i+8 +: 56] <= 56'({$urandom(), $urandom()});
            lcarry[i]             <= 1'(lane_byte(i, lstep[i], lcarry[i]) >> 8);
            lane_idx[10*i +: 10]  <= 10'(lane_bit_idx(i, lstep[i]));
            lane_done[i]          <= (lstep[i] == ref_steps(int'(lane_vsew), int'(lane_nb_lanes)) - 1)
                                     && !tie_done;
            lstep[i]              <= lstep[i] + 1;
         end
      end
   end

   // ---------------- writeback monitor / scoreboard ----------------
   initial begin
      exp_t cur;
      bit in_wb, have;
      int stall_left;
      logic [VLEN-1:0] held_data;
      logic [4:0] held_addr;
      in_wb = 1'b0;
      have = 1'b0;
      stall_left = 0;
      bus.wb_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (!resetn || !bus.wb_valid) begin
            in_wb = 1'b0;
            have = 1'b0;
            bus.wb_ready = 1'b0;
         end else begin
            if (!in_wb) begin
               in_wb = 1'b1;
               held_data = bus.wb_data;
               held_addr = bus.wb_addr;
               stall_left = (stall_req >= 0) ? stall_req : int'($urandom_range(0, 2));
               stall_req = -1;
               if (sb.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("[TB] FAIL unexpected_wb_valid: got wb_valid=1 expected 0 at cycle %0d", cyc);
                  have = 1'b0;
               end else begin
                  cur = sb.pop_front();
                  have = 1'b1;
                  chk("wb_latency", VLEN'(cyc - cur.acc), VLEN'(cur.lat));
               end
            end else begin
               chk("wb_data_stable", bus.wb_data, held_data);
               chk("wb_addr_stable", VLEN'(bus.wb_addr), VLEN'(held_addr));
            end
            if (stall_left > 0) begin
               stall_left--;
               bus.wb_ready = 1'b0;
               chk("stall_issue_ready", VLEN'(bus.issue_ready), VLEN'(0));
               chk("stall_busy", VLEN'(busy), VLEN'(1));
            end else begin
               bus.wb_ready = 1'b1;
               if (have) begin
                  chk("wb_data", bus.wb_data, cur.data);
                  chk("wb_addr", VLEN'(bus.wb_addr), VLEN'(cur.addr));
                  $display("[TB] wb addr=%0d data=%h", bus.wb_addr, bus.wb_data);
               end
               have = 1'b0;
               in_wb = 1'b0;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic do_issue(input logic [5:0] op, input logic [2:0] sew, input logic [2:0] ot,
                           input logic [1:0] nb, input logic [4:0] vd,
                           input logic [VLEN-1:0] v1, input logic [VLEN-1:0] v2,
                           input bit expect_wb, output int acc);
      int guard;
      bit legal;
      exp_t e;
      guard = 0;
      @(negedge clk);
      while (!bus.issue_ready && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 2000) begin
         n_tests++;
         n_fail++;
         $display("[TB] FAIL issue_ready_timeout: got issue_ready=0 expected 1 within 2000 cycles");
      end
      bus.issue_opcode   = op;
      bus.issue_vsew     = sew;
      bus.issue_op_type  = ot;
      bus.issue_nb_lanes = nb;
      bus.issue_vd_addr  = vd;
      bus.issue_vs1      = v1;
      bus.issue_vs2      = v2;
      bus.issue_valid    = 1'b1;
      acc   = cyc + 1;
      legal = ref_legal(op, sew, ot, nb);
      $display("[TB] issue op=%b sew=%0d type=%b nb=%0d vd=%0d legal=%0d", op, sew, ot, nb, vd, legal);
      if (legal && expect_wb) begin
         e.addr = vd;
         e.data = ref_result(op, sew, ot, v1, v2);
         e.acc  = acc;
         e.lat  = ref_steps(int'(sew), int'(nb)) + 1;
         sb.push_back(e);
      end
      @(negedge clk);
      bus.issue_valid = 1'b0;
      if (legal) begin
         chk("lane_run_mask", VLEN'(lane_run), VLEN'((1 << (1 << nb)) - 1));
         chk("lane_opcode", VLEN'(lane_opcode), VLEN'(op));
         chk("lane_vs2", lane_vs2, v2);
         chk("busy_after_accept", VLEN'(busy), VLEN'(1));
      end else begin
         chk("err_illegal_pulse", VLEN'(err_illegal), VLEN'(1));
         chk("illegal_lane_run", VLEN'(lane_run), VLEN'(0));
         chk("illegal_issue_ready", VLEN'(bus.issue_ready), VLEN'(1));
         @(negedge clk);
         chk("err_illegal_clear", VLEN'(err_illegal), VLEN'(0));
      end
   endtask

   initial begin
      int acc, guard;
      logic [5:0] op;
      logic [2:0] sew, ot;
      logic [VLEN-1:0] v1, v2;
      logic [5:0] ops[4];
      logic [2:0] ots[3];
      ops[0] = VADD; ops[1] = VAND; ops[2] = VOR; ops[3] = VXOR;
      ots[0] = VV;   ots[1] = VX;   ots[2] = VI;

      bus.issue_valid = 1'b0;
      bus.issue_opcode = '0;
      bus.issue_vsew = '0;
      bus.issue_op_type = '0;
      bus.issue_nb_lanes = '0;
      bus.issue_vd_addr = '0;
      bus.issue_vs1 = '0;
      bus.issue_vs2 = '0;

      repeat (3) @(negedge clk);
      chk("reset_issue_ready", VLEN'(bus.issue_ready), VLEN'(1));
      chk("reset_busy", VLEN'(busy), VLEN'(0));
      chk("reset_wb_valid", VLEN'(bus.wb_valid), VLEN'(0));
      chk("reset_lane_run", VLEN'(lane_run), VLEN'(0));
      chk("reset_wb_data", bus.wb_data, VLEN'(0));
      chk("reset_errs", VLEN'({err_illegal, err_timeout}), VLEN'(0));
      resetn = 1'b1;

      // vand, 8-bit elements, four lanes
      do_issue(VAND, SEW_8, VV, 2'd2, 5'd3, {VLEN{1'b1}},
               128'h0123456789ABCDEF_FEDCBA9876543210, 1'b1, acc);
      // vadd, 32-bit elements on one lane: carry ripples within elements only
      do_issue(VADD, SEW_32, VV, 2'd0, 5'd7, {4{32'h1}}, {VLEN{1'b1}}, 1'b1, acc);
      // vxor with scalar
      do_issue(VXOR, SEW_16, VX, 2'd1, 5'd9, 128'hA5A5, '0, 1'b1, acc);
      // illegal element width
      do_issue(VADD, 3'b100, VV, 2'd0, 5'd1, '1, '1, 1'b1, acc);

      // writeback held off for five cycles
      stall_req = 5;
      do_issue(VOR, SEW_8, VI, 2'd1, 5'd21, 128'h5A, 128'h0F0F_1234, 1'b1, acc);

      // reset pulse mid-run discards the instruction
      do_issue(VADD, SEW_8, VV, 2'd0, 5'd4, {$urandom(), $urandom(), $urandom(), $urandom()},
               {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0, acc);
      repeat (3) @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      chk("midreset_lane_run", VLEN'(lane_run), VLEN'(0));
      chk("midreset_busy", VLEN'(busy), VLEN'(0));
      chk("midreset_issue_ready", VLEN'(bus.issue_ready), VLEN'(1));
      chk("midreset_wb_data", bus.wb_data, VLEN'(0));
      resetn = 1'b1;
      repeat (25) @(negedge clk);

      // lanes never finish: abort after TMO cycles in RUN
      tie_done = 1'b1;
      do_issue(VAND, SEW_8, VV, 2'd2, 5'd2, '1, '1, 1'b0, acc);
      repeat (TMO - 1) @(negedge clk);
      chk("timeout_not_yet", VLEN'(err_timeout), VLEN'(0));
      chk("timeout_busy_before", VLEN'(busy), VLEN'(1));
      @(negedge clk);
      chk("err_timeout_pulse", VLEN'(err_timeout), VLEN'(1));
      chk("timeout_idle", VLEN'(busy), VLEN'(0));
      chk("timeout_lane_run", VLEN'(lane_run), VLEN'(0));
      @(negedge clk);
      chk("err_timeout_clear", VLEN'(err_timeout), VLEN'(0));
      tie_done = 1'b0;

      // randomised mix, mostly legal
      for (int n = 0; n < 40; n++) begin
         op  = ($urandom_range(0, 9) == 0) ? 6'($urandom()) : ops[$urandom_range(0, 3)];
         sew = ($urandom_range(0, 9) == 0) ? 3'($urandom()) : 3'($urandom_range(0, 3));
         ot  = ($urandom_range(0, 9) == 0) ? 3'($urandom()) : ots[$urandom_range(0, 2)];
         v1  = {$urandom(), $urandom(), $urandom(), $urandom()};
         v2  = {$urandom(), $urandom(), $urandom(), $urandom()};
         do_issue(op, sew, ot, 2'($urandom_range(0, 3)), 5'($urandom()), v1, v2, 1'b1, acc);
      end

      guard = 0;
      while ((sb.size() != 0 || busy) && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 500) begin
         n_tests++;
         n_fail++;
         $display("[TB] FAIL drain: got %0d pending writebacks expected 0", sb.size());
      end
      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
